// File: rtl/axis_play_buf.sv
// Playback buffer: prefilled FIFO of 256-bit DMA words feeding a 2:1 gearbox onto
// the 128-bit DAC stream, with zero-fill and counting on underflow.
module axis_play_buf #(
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8
) (
  input  logic                     axi_aclk,
  input  logic                     axi_rstb,
  input  logic [255:0]             s_axis_tdata,
  input  logic [31:0]              s_axis_tkeep,
  input  logic                     s_axis_tlast,
  input  logic                     s_axis_tvalid,
  output logic                     s_axis_tready,
  output logic [127:0]             m_axis_tdata,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  input  logic                     play_enable,
  input  logic                     play_reset,
  output logic [1:0]               play_state,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [15:0]              underflow_cnt,
  output logic [7:0]               frame_cnt,
  output logic                     keep_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PREFILL = 2'd1,
    ST_PLAY    = 2'd2
  } state_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  state_t          state, state_nxt;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [LW-1:0]   level;
  logic [15:0]     underflow_q;
  logic [7:0]      frame_q;
  logic            keep_err_q;

  // Each entry holds {tlast, tdata}
  logic [256:0]    mem [DEPTH];

  logic [255:0]    cur_data_p0;
  logic            cur_last_p0;
  logic            vld_p0, vld_nxt;
  logic            half_sel_p0, half_nxt;

  logic            full, empty, push, pop;
  logic            frame_inc, under_inc;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign push  = s_axis_tvalid & ~full;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    vld_nxt   = vld_p0;
    half_nxt  = half_sel_p0;
    frame_inc = 1'b0;
    under_inc = 1'b0;
    case (state)
      ST_IDLE: begin
        if (play_enable) state_nxt = ST_PREFILL;
      end
      ST_PREFILL: begin
        if (!play_enable) begin
          state_nxt = ST_IDLE;
        end else if (level >= LW'(PREFILL)) begin
          state_nxt = ST_PLAY;
          pop       = 1'b1;
          vld_nxt   = 1'b1;
          half_nxt  = 1'b0;
        end
      end
      ST_PLAY: begin
        if (!play_enable) begin
          state_nxt = ST_IDLE;
          vld_nxt   = 1'b0;
          half_nxt  = 1'b0;
        end else if (m_axis_tready) begin
          if (!half_sel_p0) begin
            half_nxt = 1'b1;
          end else begin
            // Load point: upper half just left, fetch the next word or go silent
            half_nxt  = 1'b0;
            frame_inc = vld_p0 & cur_last_p0;
            if (!empty) begin
              pop     = 1'b1;
              vld_nxt = 1'b1;
            end else begin
              vld_nxt   = 1'b0;
              under_inc = 1'b1;
            end
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge axi_aclk or negedge axi_rstb) begin
    if (!axi_rstb) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      vld_p0      <= 1'b0;
      half_sel_p0 <= 1'b0;
      underflow_q <= '0;
      frame_q     <= '0;
      keep_err_q  <= 1'b0;
    end else if (play_reset) begin
      state       <= ST_IDLE;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level       <= '0;
      vld_p0      <= 1'b0;
      half_sel_p0 <= 1'b0;
      underflow_q <= '0;
      frame_q     <= '0;
      keep_err_q  <= 1'b0;
    end else begin
      state       <= state_nxt;
      vld_p0      <= vld_nxt;
      half_sel_p0 <= half_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(push) - LW'(pop);
      if (frame_inc) frame_q <= frame_q + 8'd1;
      if (under_inc) underflow_q <= sat_inc16(underflow_q);
      if (push && (s_axis_tkeep != 32'hFFFF_FFFF)) keep_err_q <= 1'b1;
    end
  end

  // Output stage: data only, qualified by vld_p0 so it needs no reset
  always_ff @(posedge axi_aclk) begin
    if (push) mem[wr_ptr] <= {s_axis_tlast, s_axis_tdata};
    if (pop)  {cur_last_p0, cur_data_p0} <= mem[rd_ptr];
  end

  assign s_axis_tready = ~full;
  assign m_axis_tvalid = (state == ST_PLAY);
  assign m_axis_tdata  = vld_p0 ? (half_sel_p0 ? cur_data_p0[255:128] : cur_data_p0[127:0])
                                : '0;
  assign play_state    = state;
  assign fifo_level    = level;
  assign underflow_cnt = underflow_q;
  assign frame_cnt     = frame_q;
  assign keep_err      = keep_err_q;

endmodule

// File: tb/tb_axis_play_buf.sv
// Directed bench for axis_play_buf: expected beats are queued as words are accepted
// and popped as the DAC side consumes them.
module tb_axis_play_buf;

  localparam int DEPTH   = 16;
  localparam int PREFILL = 8;
  localparam int LW      = $clog2(DEPTH) + 1;

  logic           axi_aclk;
  logic           axi_rstb;
  logic [255:0]   s_axis_tdata;
  logic [31:0]    s_axis_tkeep;
  logic           s_axis_tlast;
  logic           s_axis_tvalid;
  logic           s_axis_tready;
  logic [127:0]   m_axis_tdata;
  logic           m_axis_tvalid;
  logic           m_axis_tready;
  logic           play_enable;
  logic           play_reset;
  logic [1:0]     play_state;
  logic [LW-1:0]  fifo_level;
  logic [15:0]    underflow_cnt;
  logic [7:0]     frame_cnt;
  logic           keep_err;

  axis_play_buf #(.DEPTH(DEPTH), .PREFILL(PREFILL)) dut (
    .axi_aclk      (axi_aclk),
    .axi_rstb      (axi_rstb),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .play_enable   (play_enable),
    .play_reset    (play_reset),
    .play_state    (play_state),
    .fifo_level    (fifo_level),
    .underflow_cnt (underflow_cnt),
    .frame_cnt     (frame_cnt),
    .keep_err      (keep_err)
  );

  initial axi_aclk = 1'b0;
  always #5 axi_aclk = ~axi_aclk;

  typedef struct packed {
    logic [127:0] d;
    logic         last;
  } beat_t;

  beat_t q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    zero_beats = 0;
  int    exp_frames = 0;
  logic  mon_en = 1'b0;
  logic  rand_rdy = 1'b0;

  function automatic logic [255:0] mkw(input int id);
    logic [31:0] a;
    a = 32'h1000_0000 | 32'(id);
    return {{4{a ^ 32'h3000_0000}}, {4{a}}};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: watch the DAC side at the falling edge, then step past the rising edge
  task automatic tick();
    beat_t e;
    @(negedge axi_aclk);
    if (mon_en && m_axis_tvalid && m_axis_tready) begin
      if (m_axis_tdata == '0) begin
        zero_beats++;
      end else begin
        n_cmp++;
        assert (q.size() > 0) else begin
          n_err++;
          $error("FAIL beat_extra observed=%0h expected=none", m_axis_tdata);
        end
        if (q.size() > 0) begin
          e = q.pop_front();
          n_cmp++;
          assert (m_axis_tdata === e.d) else begin
            n_err++;
            $error("FAIL beat_data observed=%0h expected=%0h", m_axis_tdata, e.d);
          end
          if (e.last) exp_frames++;
        end
      end
    end
    @(posedge axi_aclk);
    #1;
    if (rand_rdy) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic push_word(input logic [255:0] d, input logic last, input logic [31:0] keep);
    int    n;
    beat_t b;
    n = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tkeep  = keep;
    s_axis_tvalid = 1'b1;
    while (!s_axis_tready && n < 200) begin
      tick();
      n++;
    end
    chk("push_accept", 32'(s_axis_tready), 32'd1);
    if (s_axis_tready) begin
      b.d = d[127:0];   b.last = 1'b0; q.push_back(b);
      b.d = d[255:128]; b.last = last; q.push_back(b);
    end
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic drain(input string tag, input int budget);
    int n;
    n = 0;
    while (q.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  task automatic soft_clear();
    play_enable = 1'b0;
    mon_en      = 1'b0;
    tick();
    play_reset = 1'b1;
    tick();
    play_reset = 1'b0;
    q.delete();
  endtask

  initial begin
    int zb0;
    axi_rstb      = 1'b0;
    s_axis_tdata  = '0;
    s_axis_tkeep  = 32'hFFFF_FFFF;
    s_axis_tlast  = 1'b0;
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    play_enable   = 1'b0;
    play_reset    = 1'b0;
    repeat (2) @(posedge axi_aclk);
    #1;

    // Reset state
    chk("rst_state",  32'(play_state),    32'd0);
    chk("rst_level",  32'(fifo_level),    32'd0);
    chk("rst_under",  32'(underflow_cnt), 32'd0);
    chk("rst_frame",  32'(frame_cnt),     32'd0);
    chk("rst_keep",   32'(keep_err),      32'd0);
    chk("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("rst_tdata",  32'(m_axis_tdata[31:0] | m_axis_tdata[127:96]), 32'd0);
    axi_rstb = 1'b1;
    tick();

    // Prefill and play, then underflow
    play_enable = 1'b1;
    mon_en      = 1'b1;
    tick();
    chk("pf_state", 32'(play_state), 32'd1);
    for (int i = 0; i < 8; i++) push_word(mkw(i), 1'b0, 32'hFFFF_FFFF);
    chk("pf_level8", 32'(fifo_level), 32'd8);
    chk("pf_still_prefill", 32'(play_state), 32'd1);
    tick();
    chk("pf_play", 32'(play_state), 32'd2);
    chk("pf_level7", 32'(fifo_level), 32'd7);
    chk("pf_tvalid", 32'(m_axis_tvalid), 32'd1);
    zb0 = zero_beats;
    repeat (16) tick();
    chk("play_nogap_q", 32'(q.size()), 32'd0);
    chk("play_nogap_z", 32'(zero_beats - zb0), 32'd0);
    chk("uf_first", 32'(underflow_cnt), 32'd1);
    repeat (6) tick();
    chk("uf_four", 32'(underflow_cnt), 32'd4);
    push_word(mkw(8), 1'b0, 32'hFFFF_FFFF);
    tick();
    chk("uf_hold", 32'(underflow_cnt), 32'd4);
    chk("uf_zero_beats", 32'(zero_beats - zb0), 32'd8);
    repeat (2) tick();
    chk("uf_resume", 32'(q.size()), 32'd0);
    play_enable = 1'b0;
    mon_en      = 1'b0;
    tick();
    chk("stop_state", 32'(play_state), 32'd0);
    chk("stop_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("stop_tdata", 32'(m_axis_tdata[31:0]), 32'd0);
    soft_clear();
    chk("clr_under", 32'(underflow_cnt), 32'd0);

    // Full backpressure
    for (int i = 0; i < 16; i++) push_word(mkw(100 + i), 1'b0, 32'hFFFF_FFFF);
    chk("full_level", 32'(fifo_level), 32'd16);
    chk("full_tready", 32'(s_axis_tready), 32'd0);
    s_axis_tdata  = mkw(116);
    s_axis_tvalid = 1'b1;
    repeat (3) tick();
    chk("full_hold_level", 32'(fifo_level), 32'd16);
    chk("full_hold_tready", 32'(s_axis_tready), 32'd0);
    play_enable = 1'b1;
    mon_en      = 1'b1;
    tick();
    chk("full_pf_state", 32'(play_state), 32'd1);
    chk("full_pf_tready", 32'(s_axis_tready), 32'd0);
    tick();
    chk("full_pop_state", 32'(play_state), 32'd2);
    chk("full_pop_level", 32'(fifo_level), 32'd15);
    chk("full_pop_tready", 32'(s_axis_tready), 32'd1);
    for (int i = 16; i < 20; i++) push_word(mkw(100 + i), 1'b0, 32'hFFFF_FFFF);
    drain("full_drain", 300);
    soft_clear();

    // DAC stall with tlast on every 4th word
    chk("frm_clear", 32'(frame_cnt), 32'd0);
    exp_frames  = 0;
    rand_rdy    = 1'b1;
    play_enable = 1'b1;
    mon_en      = 1'b1;
    for (int i = 0; i < 24; i++) push_word(mkw(200 + i), (i % 4) == 3, 32'hFFFF_FFFF);
    drain("stall_drain", 2000);
    rand_rdy      = 1'b0;
    m_axis_tready = 1'b1;
    repeat (2) tick();
    chk("frm_played", 32'(exp_frames), 32'd6);
    chk("frm_cnt", 32'(frame_cnt), 32'(exp_frames));

    // Synchronous clear in the middle of playback
    for (int i = 0; i < 12; i++) push_word(mkw(300 + i), 1'b0, 32'hFFFF_FFFF);
    mon_en      = 1'b0;
    play_enable = 1'b0;
    play_reset  = 1'b1;
    tick();
    play_reset = 1'b0;
    q.delete();
    chk("prst_state",  32'(play_state),    32'd0);
    chk("prst_level",  32'(fifo_level),    32'd0);
    chk("prst_under",  32'(underflow_cnt), 32'd0);
    chk("prst_frame",  32'(frame_cnt),     32'd0);
    chk("prst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("prst_tready", 32'(s_axis_tready), 32'd1);

    // Asynchronous reset in the middle of playback
    play_enable = 1'b1;
    mon_en      = 1'b1;
    for (int i = 0; i < 10; i++) push_word(mkw(400 + i), 1'b0, 32'hFFFF_FFFF);
    repeat (3) tick();
    chk("arst_pre_state", 32'(play_state), 32'd2);
    mon_en      = 1'b0;
    play_enable = 1'b0;
    #2;
    axi_rstb = 1'b0;
    #1;
    chk("arst_state",  32'(play_state),    32'd0);
    chk("arst_level",  32'(fifo_level),    32'd0);
    chk("arst_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("arst_tdata",  32'(m_axis_tdata[31:0] | m_axis_tdata[127:96]), 32'd0);
    axi_rstb = 1'b1;
    q.delete();
    @(posedge axi_aclk);
    #1;

    // Partial tkeep is flagged but still played
    play_enable = 1'b1;
    mon_en      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push_word(mkw(500 + i), 1'b0, (i == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF);
      if (i == 1) chk("keep_before", 32'(keep_err), 32'd0);
      if (i == 2) chk("keep_set", 32'(keep_err), 32'd1);
    end
    drain("keep_drain", 300);
    chk("keep_sticky", 32'(keep_err), 32'd1);
    soft_clear();
    chk("keep_cleared", 32'(keep_err), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
